pc_sequencer: RTL and testbench

Multi-cycle program-counter sequencer for the RISC-V core. Owns the PC register, fetches each instruction over a request/acknowledge handshake, hands it to decode/execute, then waits for execute to report branch resolution. It computes the next PC from the branch condition code, immediate and ALU flags using the same condition encoding the branch logic uses, and traps on misaligned targets.

---
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Multi-cycle program-counter sequencer. Fetches over a req/ack
//            handshake, offers the instruction to decode, waits for execute
//            to resolve the branch, then computes the next PC. A taken branch
//            to a misaligned target raises a sticky trap and stops fetching.
//            Optional macro BRANCH_STATS_EN adds taken/not-taken counters.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready,
    input  logic        i_ex_done,
    input  logic [2:0]  i_ex_opcode,
    input  logic [31:0] i_ex_imm,
    input  logic        i_ex_z,
    input  logic [31:0] i_ex_d,
    input  logic        i_halt,
    output logic [31:0] o_pc,
`ifdef BRANCH_STATS_EN
    output logic [31:0] o_taken_cnt,
    output logic [31:0] o_ntaken_cnt,
`endif
    output logic        o_misalign
);

    localparam logic [31:0] c_RESET_PC = RESET_VECTOR & ~32'h0000_0003;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_ISSUE  = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_HALTED = 3'd4;
    localparam logic [2:0] c_TRAP   = 3'd5;

    localparam logic [2:0] c_OP_ZER = 3'd1;
    localparam logic [2:0] c_OP_NZR = 3'd2;
    localparam logic [2:0] c_OP_DAT = 3'd3;
    localparam logic [2:0] c_OP_NDT = 3'd4;
    localparam logic [2:0] c_OP_JMP = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_misalign;
    logic        w_take;
    logic [31:0] w_target;
    logic        w_resolve;
    logic        w_bad_target;

    // Branch condition decode, shared encoding with the branch unit
    always_comb begin
        w_take = 1'b0;
        case (i_ex_opcode)
            c_OP_ZER: w_take = i_ex_z;
            c_OP_NZR: w_take = ~i_ex_z;
            c_OP_DAT: w_take = |i_ex_d;
            c_OP_NDT: w_take = ~(|i_ex_d);
            c_OP_JMP: w_take = 1'b1;
            default:  w_take = 1'b0;
        endcase
    end

    // Only a taken branch can land misaligned; PC+4 from an aligned PC never does
    assign w_target     = w_take ? (r_pc + i_ex_imm) : (r_pc + 32'd4);
    assign w_resolve    = (r_state == c_EXEC) && i_ex_done;
    assign w_bad_target = w_take && (w_target[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   w_next_state = i_halt ? c_HALTED : c_FETCH;
            c_FETCH:  if (i_imem_ack)    w_next_state = c_ISSUE;
            c_ISSUE:  if (i_instr_ready) w_next_state = c_EXEC;
            c_EXEC: begin
                if (i_ex_done) begin
                    if (w_bad_target)  w_next_state = c_TRAP;
                    else if (i_halt)   w_next_state = c_HALTED;
                    else               w_next_state = c_FETCH;
                end
            end
            c_HALTED: if (!i_halt)   w_next_state = c_FETCH;
            c_TRAP:   w_next_state = c_TRAP;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // Outputs decoded from state only, so no input reaches an output combinationally
    always_comb begin
        o_imem_req    = (r_state == c_FETCH);
        o_instr_valid = (r_state == c_ISSUE);
    end

    // Datapath: instruction latch, PC update and sticky trap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= c_RESET_PC;
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            if ((r_state == c_FETCH) && i_imem_ack) begin
                r_instr    <= i_imem_data;
                r_instr_pc <= r_pc;
            end
            if (w_resolve) begin
                if (w_bad_target) r_misalign <= 1'b1;
                else              r_pc       <= w_target;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_taken_cnt;
    logic [31:0] r_ntaken_cnt;

    // Branch statistics; trapping branches count as taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt  <= 32'd0;
            r_ntaken_cnt <= 32'd0;
        end else if (w_resolve) begin
            if (w_take) r_taken_cnt  <= r_taken_cnt + 32'd1;
            else        r_ntaken_cnt <= r_ntaken_cnt + 32'd1;
        end
    end

    assign o_taken_cnt  = r_taken_cnt;
    assign o_ntaken_cnt = r_ntaken_cnt;
`endif

    assign o_imem_addr = r_pc;
    assign o_pc        = r_pc;
    assign o_instr     = r_instr;
    assign o_instr_pc  = r_instr_pc;
    assign o_misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed bench for pc_sequencer with hand-computed PC values.
//            Define BRANCH_STATS_EN to also exercise the branch counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        ex_done = 1'b0;
    logic [2:0]  ex_opcode = 3'd0;
    logic [31:0] ex_imm = 32'd0;
    logic        ex_z = 1'b0;
    logic [31:0] ex_d = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic        misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt;
    logic [31:0] ntaken_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_VECTOR(32'h0000_0103)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (imem_ack),
        .i_imem_data   (imem_data),
        .o_instr_valid (instr_valid),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .i_instr_ready (instr_ready),
        .i_ex_done     (ex_done),
        .i_ex_opcode   (ex_opcode),
        .i_ex_imm      (ex_imm),
        .i_ex_z        (ex_z),
        .i_ex_d        (ex_d),
        .i_halt        (halt),
        .o_pc          (pc),
`ifdef BRANCH_STATS_EN
        .o_taken_cnt   (taken_cnt),
        .o_ntaken_cnt  (ntaken_cnt),
`endif
        .o_misalign    (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full FETCH/ISSUE/EXEC pass; entered and left at a falling edge.
    // noise drives stray EX_DONE / IMEM_ACK while they must be ignored.
    task automatic run_instr(input logic [2:0] op, input logic [31:0] imm, input logic z,
                             input logic [31:0] d, input logic h, input logic [31:0] data,
                             input int ack_dly, input int rdy_dly,
                             input logic [31:0] pc_now, input logic [31:0] pc_exp,
                             input bit noise);
        for (int i = 0; i <= ack_dly; i++) begin
            chk("fetch_req", {31'd0, imem_req}, 32'd1);
            chk("fetch_addr", imem_addr, pc_now);
            if (i == ack_dly) begin
                imem_ack  = 1'b1;
                imem_data = data;
                ex_done   = 1'b0;
            end else begin
                imem_data = ~data;
                ex_done   = noise;
                ex_opcode = 3'd5;
                ex_imm    = 32'd8;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("issue_valid", {31'd0, instr_valid}, 32'd1);
            chk("issue_req", {31'd0, imem_req}, 32'd0);
            chk("issue_instr", instr, data);
            chk("issue_ipc", instr_pc, pc_now);
            if (i == rdy_dly) begin
                instr_ready = 1'b1;
                ex_done     = 1'b0;
                imem_ack    = 1'b0;
            end else begin
                ex_done   = noise;
                imem_ack  = noise;
                imem_data = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        chk("exec_valid", {31'd0, instr_valid}, 32'd0);
        chk("exec_pc_hold", pc, pc_now);
        ex_done   = 1'b1;
        ex_opcode = op;
        ex_imm    = imm;
        ex_z      = z;
        ex_d      = d;
        halt      = h;
        @(negedge clk);
        ex_done = 1'b0;
        chk("next_pc", pc, pc_exp);
    endtask

    initial begin
        // Reset and first fetch
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_pc", pc, 32'h0000_0100);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        @(negedge clk);

        // Conditional branches and fall-throughs
        run_instr(3'd1, 32'h20,         1'b1, 32'd0, 1'b0, 32'hA000_0001, 0, 0, 32'h100, 32'h120, 1'b0);
        run_instr(3'd5, 32'hFFFF_FFE0, 1'b0, 32'd0, 1'b0, 32'hA000_0002, 0, 0, 32'h120, 32'h100, 1'b0);
        run_instr(3'd1, 32'h20,         1'b0, 32'd0, 1'b0, 32'hA000_0003, 0, 0, 32'h100, 32'h104, 1'b0);
        run_instr(3'd5, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'hA000_0004, 0, 0, 32'h104, 32'h100, 1'b0);
        run_instr(3'd3, 32'h40,         1'b0, 32'd0, 1'b0, 32'hA000_0005, 0, 0, 32'h100, 32'h104, 1'b0);
        run_instr(3'd5, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'hA000_0006, 0, 0, 32'h104, 32'h100, 1'b0);
        run_instr(3'd4, 32'hFFFF_FFF0, 1'b0, 32'd0, 1'b0, 32'hA000_0007, 0, 0, 32'h100, 32'h0F0, 1'b0);
        run_instr(3'd0, 32'h10,         1'b1, 32'd1, 1'b0, 32'hA000_0008, 0, 0, 32'h0F0, 32'h0F4, 1'b0);
        run_instr(3'd6, 32'h10,         1'b1, 32'd1, 1'b0, 32'hA000_0009, 0, 0, 32'h0F4, 32'h0F8, 1'b0);
        run_instr(3'd7, 32'h10,         1'b1, 32'd1, 1'b0, 32'hA000_000A, 0, 0, 32'h0F8, 32'h0FC, 1'b0);
        run_instr(3'd3, 32'h4,          1'b0, 32'd5, 1'b0, 32'hA000_000B, 0, 0, 32'h0FC, 32'h100, 1'b0);
        run_instr(3'd2, 32'h40,         1'b1, 32'd0, 1'b0, 32'hA000_000C, 0, 0, 32'h100, 32'h104, 1'b0);

        // Wrap-around at the top of the address space
        run_instr(3'd5, 32'hFFFF_FEF8, 1'b0, 32'd0, 1'b0, 32'hA000_000D, 0, 0, 32'h104, 32'hFFFF_FFFC, 1'b0);
        run_instr(3'd0, 32'h0,          1'b0, 32'd0, 1'b0, 32'hA000_000E, 0, 0, 32'hFFFF_FFFC, 32'h0, 1'b0);
        run_instr(3'd5, 32'h100,        1'b0, 32'd0, 1'b0, 32'hA000_000F, 0, 0, 32'h0, 32'h100, 1'b0);

        // Slow handshakes with stray strobes, HALT coincident with EX_DONE
        run_instr(3'd0, 32'h0, 1'b0, 32'd0, 1'b1, 32'h5A5A_1234, 3, 2, 32'h100, 32'h104, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_pc", pc, 32'h104);
            @(negedge clk);
        end
        halt = 1'b0;
        @(negedge clk);
        run_instr(3'd5, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'hA000_0010, 0, 0, 32'h104, 32'h100, 1'b0);

        // Misaligned taken branch traps and freezes the PC
        chk("pre_trap_mis", {31'd0, misalign}, 32'd0);
        run_instr(3'd5, 32'h6, 1'b0, 32'd0, 1'b0, 32'hA000_0011, 0, 0, 32'h100, 32'h100, 1'b0);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            ex_done  = 1'b1;
            chk("trap_mis", {31'd0, misalign}, 32'd1);
            chk("trap_req", {31'd0, imem_req}, 32'd0);
            chk("trap_pc", pc, 32'h100);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        ex_done  = 1'b0;
`ifdef BRANCH_STATS_EN
        chk("taken_cnt", taken_cnt, 32'd10);
        chk("ntaken_cnt", ntaken_cnt, 32'd8);
`endif

        // Reset clears the trap; then reset again in the middle of a fetch
        rst_n = 1'b0;
        #1;
        chk("rst2_mis", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        chk("refetch_hold", imem_addr, 32'h100);
        rst_n = 1'b0;
        #1;
        chk("midfetch_req", {31'd0, imem_req}, 32'd0);
        chk("midfetch_pc", pc, 32'h100);
`ifdef BRANCH_STATS_EN
        chk("rst_taken", taken_cnt, 32'd0);
        chk("rst_ntaken", ntaken_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_instr(3'd1, 32'h8, 1'b1, 32'd0, 1'b0, 32'hA000_0012, 0, 0, 32'h100, 32'h108, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop if the directed sequence ever stalls
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
